// File: rtl/smol_stream_fifo.sv
// smol_stream_fifo: first-word-fall-through valid/ready FIFO, flags from registered state.
// Optional SMOL_FIFO_STATS_EN adds the xfer_cnt downstream transfer counter.
module smol_stream_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_vld,
  output logic                    s_rdy,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    m_vld,
  input  logic                    m_rdy,
  output logic [DATA_W-1:0]       m_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    afull
`ifdef SMOL_FIFO_STATS_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;

  assign s_rdy  = (cnt != CW'(DEPTH));
  assign m_vld  = (cnt != '0);
  assign push   = s_vld & s_rdy;
  assign pop    = m_vld & m_rdy;
  assign m_data = mem[rd_ptr];
  assign count  = cnt;
  assign afull  = (cnt >= CW'(AFULL_LVL));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is never reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

`ifdef SMOL_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      xfer_cnt <= '0;
    else if (pop)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_smol_stream_fifo.sv
// tb_smol_stream_fifo: vector table plus scoreboard for smol_stream_fifo.
// Stats checks compile in when SMOL_FIFO_STATS_EN is defined.
module tb_smol_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic [31:0] s_data = '0;
  logic        m_vld;
  logic        m_rdy = 1'b0;
  logic [31:0] m_data;
  logic [2:0]  count;
  logic        afull;
`ifdef SMOL_FIFO_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  smol_stream_fifo #(
    .DATA_W(32),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_vld(s_vld),
    .s_rdy(s_rdy),
    .s_data(s_data),
    .m_vld(m_vld),
    .m_rdy(m_rdy),
    .m_data(m_data),
    .count(count),
    .afull(afull)
`ifdef SMOL_FIFO_STATS_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [15:0] exp_xfer = '0;

  typedef struct {
    logic        r;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    int          cnt;
    logic        mv;
    logic        sr;
    logic        af;
    logic [31:0] md;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic sv,
                     input logic [31:0] sd, input logic mr);
    rst    = r;
    s_vld  = sv;
    s_data = sd;
    m_rdy  = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // handshakes are stable from just after one edge until the next
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        exp_xfer = '0;
      end else begin
        if (m_vld && m_rdy) begin
          exp_xfer = exp_xfer + 16'd1;
          n_vec++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_pop: got %h expected none", m_data);
          end else begin
            exp = sb_q.pop_front();
            if (m_data !== exp) begin
              n_err++;
              $display("FAIL sb_order: got %h expected %h", m_data, exp);
            end
          end
        end
        if (s_vld && s_rdy)
          sb_q.push_back(s_data);
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,    1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h1,    1'b0, 1, 1'b1, 1'b1, 1'b0, 32'h1};
    tbl[2]  = '{1'b0, 1'b1, 32'h2,    1'b0, 2, 1'b1, 1'b1, 1'b0, 32'h1};
    tbl[3]  = '{1'b0, 1'b1, 32'h3,    1'b0, 3, 1'b1, 1'b1, 1'b1, 32'h1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,    1'b0, 3, 1'b1, 1'b1, 1'b1, 32'h1};
    tbl[5]  = '{1'b0, 1'b1, 32'h4,    1'b0, 4, 1'b1, 1'b0, 1'b1, 32'h1};
    tbl[6]  = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 4, 1'b1, 1'b0, 1'b1, 32'h1};
    tbl[7]  = '{1'b0, 1'b1, 32'hDEAD, 1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h2};
    tbl[8]  = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 4, 1'b1, 1'b0, 1'b1, 32'h2};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h3};
    tbl[10] = '{1'b0, 1'b1, 32'h5,    1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h4};
    tbl[11] = '{1'b1, 1'b1, 32'h6,    1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 32'h7,    1'b0, 1, 1'b1, 1'b1, 1'b0, 32'h7};
    tbl[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,    1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 32'h9,    1'b1, 1, 1'b1, 1'b1, 1'b0, 32'h9};
    tbl[16] = '{1'b0, 1'b0, 32'h0,    1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].r, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_m_vld", i), 32'(m_vld), 32'(tbl[i].mv));
      chk($sformatf("v%0d_s_rdy", i), 32'(s_rdy), 32'(tbl[i].sr));
      chk($sformatf("v%0d_afull", i), 32'(afull), 32'(tbl[i].af));
      if (tbl[i].mv)
        chk($sformatf("v%0d_m_data", i), m_data, tbl[i].md);
    end

    // back-to-back streaming at full throughput
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 1'b1, 32'(i), 1'b1);
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_m_vld", 32'(m_vld), 32'd1);
      chk("stream_m_data", m_data, 32'(i));
    end
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("stream_drain", 32'(count), 32'd0);

    // random traffic against the scoreboard
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    for (int c = 0; c < 1000; c++) begin
      drv(1'b0, 1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1))));
      step();
      chk("rnd_count", 32'(count), 32'(sb_q.size()));
      chk("rnd_m_vld", 32'(m_vld), 32'(sb_q.size() != 0));
      chk("rnd_s_rdy", 32'(s_rdy), 32'(sb_q.size() != 4));
      if (sb_q.size() != 0)
        chk("rnd_head", m_data, sb_q[0]);
    end
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 10 && count != 0; k++)
      step();
    chk("rnd_drain_count", 32'(count), 32'd0);
    chk("rnd_drain_sb", 32'(sb_q.size()), 32'd0);

`ifdef SMOL_FIFO_STATS_EN
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("xfer_reset", 32'(xfer_cnt), 32'd0);
    for (int k = 0; k < 65538; k++) begin
      drv(1'b0, 1'b1, 32'(k), 1'b1);
      step();
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("xfer_model", 32'(xfer_cnt), 32'(exp_xfer));
    chk("xfer_wrap", 32'(xfer_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
